// File: rtl/crc_pkg.sv
// Shared types, helpers and preset constants for the CRC stream engine.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } crc_state_e;

  // Reverse the low w bits of v (w <= 32); bits above w come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [4:0]  j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        j = 5'(w - 1 - i);
        r[i] = v[j];
      end
    end
    return r;
  endfunction

  // CRC-16/ARC
  localparam logic [15:0] CRC16_ARC_POLY    = 16'h8005;
  localparam logic [15:0] CRC16_ARC_INIT    = 16'h0000;
  localparam logic [15:0] CRC16_ARC_XOR_OUT = 16'h0000;
  localparam bit          CRC16_ARC_REFIN   = 1'b1;
  localparam bit          CRC16_ARC_REFOUT  = 1'b1;

  // CRC-16/CCITT-FALSE
  localparam logic [15:0] CRC16_CCITT_FALSE_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_FALSE_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_FALSE_XOR_OUT = 16'h0000;
  localparam bit          CRC16_CCITT_FALSE_REFIN   = 1'b0;
  localparam bit          CRC16_CCITT_FALSE_REFOUT  = 1'b0;

  // CRC-32 (IEEE 802.3)
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
  localparam bit          CRC32_REFIN   = 1'b1;
  localparam bit          CRC32_REFOUT  = 1'b1;

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update: folds DATA_W data bits (MSB first) into the register.
module crc_step #(
  parameter int               CRC_W  = 16,
  parameter logic [CRC_W-1:0] POLY   = CRC_W'(16'h8005),
  parameter int               DATA_W = 8
) (
  input  logic [CRC_W-1:0]  crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_o
);

  // Unrolled LFSR: one shift/conditional-XOR per data bit
  always_comb begin
    logic [CRC_W-1:0] r;
    logic             fb;
    r  = crc_i;
    fb = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ data_i[i];
      r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    end
    crc_o = r;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed, word-parallel CRC engine with valid/ready input and result handshakes.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_IDLE   | no frame open; register holds INIT, next beat starts a frame
//   ST_ACCUM  | frame open; beats fold into the running register
//   ST_RESULT | final CRC held on res_o until the consumer takes it
module crc_stream_engine import crc_pkg::*; #(
  parameter int               CRC_W   = 16,
  parameter logic [CRC_W-1:0] POLY    = CRC_W'(16'h8005),
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter logic [CRC_W-1:0] XOR_OUT = '0,
  parameter int               DATA_W  = 8,
  parameter bit               REFIN   = 1'b0,
  parameter bit               REFOUT  = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CRC_W-1:0]  crc_state_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CRC_W-1:0]  res_o
);

  if (DATA_W < 1 || CRC_W < 8 || CRC_W > 32) begin : g_bad_params
    $fatal(1, "crc_stream_engine: need DATA_W >= 1 and 8 <= CRC_W <= 32");
  end

  crc_state_e       state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] res_q;
  logic [CRC_W-1:0] step_base;
  logic [CRC_W-1:0] step_out;
  logic [CRC_W-1:0] res_d;
  logic [DATA_W-1:0] data_in;
  logic             accept;

  assign accept = valid_i && (state_q != ST_RESULT);

  // Optional bit reversal of each input word before it enters the LFSR
  always_comb begin
    data_in = data_i;
    if (REFIN) begin
      for (int i = 0; i < DATA_W; i++) begin
        data_in[i] = data_i[DATA_W-1-i];
      end
    end
  end

  // A frame starts from INIT when idle or when sop restarts an open frame
  always_comb begin
    step_base = INIT;
    if (state_q == ST_ACCUM && !sop_i) begin
      step_base = crc_q;
    end
  end

  crc_step #(
    .CRC_W  (CRC_W),
    .POLY   (POLY),
    .DATA_W (DATA_W)
  ) u_step (
    .crc_i  (step_base),
    .data_i (data_in),
    .crc_o  (step_out)
  );

  // Final result from the post-eop register: optional reversal, then XOR_OUT
  always_comb begin
    res_d = step_out;
    if (REFOUT) begin
      for (int i = 0; i < CRC_W; i++) begin
        res_d[i] = step_out[CRC_W-1-i];
      end
    end
    res_d = res_d ^ XOR_OUT;
  end

  // Frame sequencing, running register and held result
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT;
      res_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            crc_q <= step_out;
            if (eop_i) begin
              state_q <= ST_RESULT;
              res_q   <= res_d;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_RESULT: begin
          if (res_ready_i) begin
            state_q <= ST_IDLE;
            crc_q   <= INIT;
            res_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          crc_q   <= INIT;
          res_q   <= '0;
        end
      endcase
    end
  end

  assign ready_o     = (state_q != ST_RESULT);
  assign res_valid_o = (state_q == ST_RESULT);
  assign res_o       = res_q;
  assign crc_state_o = crc_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: four 8-bit engines (BUYPASS, ARC, CCITT-FALSE,
// CRC-32) share one stimulus stream, plus a 1-bit serial engine on its own.
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // shared 8-bit stimulus
  logic       valid = 1'b0, sop = 1'b0, eop = 1'b0, rr = 1'b0;
  logic [7:0] data = 8'h00;
  // serial stimulus
  logic       vs = 1'b0, ss = 1'b0, es = 1'b0, rrs = 1'b0;
  logic [0:0] ds = 1'b0;

  logic [15:0] st_b, res_b, st_a, res_a, st_c, res_c, st_s, res_s;
  logic [31:0] st_32, res_32;
  logic        rdy_b, rv_b, rdy_a, rv_a, rdy_c, rv_c, rdy_32, rv_32, rdy_s, rv_s;

  crc_stream_engine u_buypass (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy_b), .sop_i(sop), .eop_i(eop),
    .data_i(data), .crc_state_o(st_b), .res_valid_o(rv_b), .res_ready_i(rr), .res_o(res_b));

  crc_stream_engine #(.CRC_W(16), .POLY(CRC16_ARC_POLY), .INIT(CRC16_ARC_INIT),
    .XOR_OUT(CRC16_ARC_XOR_OUT), .DATA_W(8), .REFIN(CRC16_ARC_REFIN), .REFOUT(CRC16_ARC_REFOUT)
  ) u_arc (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy_a), .sop_i(sop), .eop_i(eop),
    .data_i(data), .crc_state_o(st_a), .res_valid_o(rv_a), .res_ready_i(rr), .res_o(res_a));

  crc_stream_engine #(.CRC_W(16), .POLY(CRC16_CCITT_FALSE_POLY), .INIT(CRC16_CCITT_FALSE_INIT),
    .XOR_OUT(CRC16_CCITT_FALSE_XOR_OUT), .DATA_W(8), .REFIN(CRC16_CCITT_FALSE_REFIN),
    .REFOUT(CRC16_CCITT_FALSE_REFOUT)
  ) u_ccitt (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy_c), .sop_i(sop), .eop_i(eop),
    .data_i(data), .crc_state_o(st_c), .res_valid_o(rv_c), .res_ready_i(rr), .res_o(res_c));

  crc_stream_engine #(.CRC_W(32), .POLY(CRC32_POLY), .INIT(CRC32_INIT), .XOR_OUT(CRC32_XOR_OUT),
    .DATA_W(8), .REFIN(CRC32_REFIN), .REFOUT(CRC32_REFOUT)
  ) u_crc32 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(rdy_32), .sop_i(sop), .eop_i(eop),
    .data_i(data), .crc_state_o(st_32), .res_valid_o(rv_32), .res_ready_i(rr), .res_o(res_32));

  crc_stream_engine #(.CRC_W(16), .POLY(16'h8005), .INIT(16'h0000), .XOR_OUT(16'h0000),
    .DATA_W(1), .REFIN(1'b0), .REFOUT(1'b0)
  ) u_serial (
    .clk_i(clk), .rst_i(rst_n), .valid_i(vs), .ready_o(rdy_s), .sop_i(ss), .eop_i(es),
    .data_i(ds), .crc_state_o(st_s), .res_valid_o(rv_s), .res_ready_i(rrs), .res_o(res_s));

  longint unsigned st [5];
  longint unsigned res[5];
  logic            rdy[5];
  logic            rv [5];

  always_comb begin
    st[0] = 64'(st_b);  res[0] = 64'(res_b);  rdy[0] = rdy_b;  rv[0] = rv_b;
    st[1] = 64'(st_a);  res[1] = 64'(res_a);  rdy[1] = rdy_a;  rv[1] = rv_a;
    st[2] = 64'(st_c);  res[2] = 64'(res_c);  rdy[2] = rdy_c;  rv[2] = rv_c;
    st[3] = 64'(st_32); res[3] = 64'(res_32); rdy[3] = rdy_32; rv[3] = rv_32;
    st[4] = 64'(st_s);  res[4] = 64'(res_s);  rdy[4] = rdy_s;  rv[4] = rv_s;
  end

  // ---------------- reference model ----------------
  localparam int              CW[5] = '{16, 16, 16, 32, 16};
  localparam int              DW[5] = '{8, 8, 8, 8, 1};
  localparam longint unsigned PL[5] = '{64'h8005, 64'h8005, 64'h1021, 64'h04C11DB7, 64'h8005};
  localparam longint unsigned IN[5] = '{64'h0, 64'h0, 64'hFFFF, 64'hFFFFFFFF, 64'h0};
  localparam longint unsigned XO[5] = '{64'h0, 64'h0, 64'h0, 64'hFFFFFFFF, 64'h0};
  localparam bit              RI[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit              RO[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  string NM[5] = '{"buypass", "arc", "ccitt", "crc32", "serial"};

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input longint unsigned got, input longint unsigned exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  function automatic longint unsigned rev(input longint unsigned v, input int w);
    return 64'(bit_reverse(v[31:0], w));
  endfunction

  // Word-at-a-time division: XOR the word into the top of the register, then
  // shift out dw bits, reducing by the polynomial whenever a one falls off.
  function automatic longint unsigned mstep(input longint unsigned r, input longint unsigned d,
                                            input int k);
    longint unsigned mask = (64'd1 << CW[k]) - 64'd1;
    longint unsigned w = RI[k] ? rev(d, DW[k]) : d;
    r = r ^ (w << (CW[k] - DW[k]));
    for (int i = 0; i < DW[k]; i++) begin
      if (((r >> (CW[k] - 1)) & 64'd1) != 0) r = ((r << 1) & mask) ^ PL[k];
      else                                    r = (r << 1) & mask;
    end
    return r;
  endfunction

  function automatic longint unsigned mfinal(input longint unsigned r, input int k);
    return (RO[k] ? rev(r, CW[k]) : r) ^ XO[k];
  endfunction

  logic [7:0] msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  function automatic longint unsigned msg_crc(input int k);
    longint unsigned r = IN[k];
    for (int i = 0; i < 9; i++) r = mstep(r, 64'(msg[i]), k);
    return mfinal(r, k);
  endfunction

  // model frame status: 0 = no frame, 1 = frame open, 2 = result pending
  int              ms  [5];
  longint unsigned mreg[5];
  longint unsigned mres[5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        ms[k] <= 0; mreg[k] <= IN[k]; mres[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        bit v, s, e, r;
        longint unsigned d, n;
        v = (k == 4) ? vs : valid;
        s = (k == 4) ? ss : sop;
        e = (k == 4) ? es : eop;
        r = (k == 4) ? rrs : rr;
        d = (k == 4) ? 64'(ds) : 64'(data);
        if (ms[k] == 2) begin
          if (r) begin ms[k] <= 0; mreg[k] <= IN[k]; mres[k] <= 0; end
        end else if (v) begin
          n = mstep((ms[k] == 0 || s) ? IN[k] : mreg[k], d, k);
          mreg[k] <= n;
          if (e) begin ms[k] <= 2; mres[k] <= mfinal(n, k); end
          else ms[k] <= 1;
        end
      end
    end
  end

  // every-cycle comparison of all engines against the model
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_ready", NM[k]), 64'(rdy[k]), 64'(ms[k] != 2));
      chk($sformatf("%s_res_valid", NM[k]), 64'(rv[k]), 64'(ms[k] == 2));
      chk($sformatf("%s_res", NM[k]), res[k], (ms[k] == 2) ? mres[k] : 64'd0);
      chk($sformatf("%s_state", NM[k]), st[k], mreg[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input bit ser, input logic [7:0] d, input bit s, input bit e);
    int  n;
    bit  acc;
    if (ser) begin vs = 1'b1; ds = d[0:0]; ss = s; es = e; end
    else begin valid = 1'b1; data = d; sop = s; eop = e; end
    n = 0;
    forever begin
      @(negedge clk);
      acc = ser ? rdy[4] : rdy[0];
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 40) begin
        total_cnt++;
        $display("FAIL beat_accept: got ready=0 required ready=1 within 40 cycles");
        break;
      end
    end
    vs = 1'b0; valid = 1'b0; ss = 1'b0; es = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  // returns on a falling edge with the result visible
  task automatic wait_res(input bit ser);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (ser ? rv[4] : rv[0]) break;
      n++;
      if (n > 40) begin
        total_cnt++;
        $display("FAIL wait_result: got res_valid=0 required res_valid=1 within 40 cycles");
        break;
      end
    end
  endtask

  task automatic pop(input bit ser);
    if (ser) rrs = 1'b1; else rr = 1'b1;
    @(posedge clk); #1;
    rrs = 1'b0; rr = 1'b0;
  endtask

  task automatic send_msg();
    for (int i = 0; i < 9; i++) beat(1'b0, msg[i], i == 0, i == 8);
  endtask

  task automatic chk_msg_literals(input string tag);
    chk({tag, "_buypass"}, res[0], 64'hFEE8);
    chk({tag, "_arc"},     res[1], 64'hBB3D);
    chk({tag, "_ccitt"},   res[2], 64'h29B1);
    chk({tag, "_crc32"},   res[3], 64'hCBF43926);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // the model itself against known check values
    chk("model_pin_buypass", msg_crc(0), 64'hFEE8);
    chk("model_pin_arc",     msg_crc(1), 64'hBB3D);
    chk("model_pin_ccitt",   msg_crc(2), 64'h29B1);
    chk("model_pin_crc32",   msg_crc(3), 64'hCBF43926);
    chk("model_pin_serial",  mfinal(mstep(64'd0, 64'd1, 4), 4), 64'h8005);

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(rdy[0]), 64'd1);
    chk("reset_res_valid", 64'(rv[0]), 64'd0);
    chk("reset_res", res[0], 64'd0);
    chk("reset_state_ccitt", st[2], 64'hFFFF);
    chk("reset_state_crc32", st[3], 64'hFFFFFFFF);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // check string through all four 8-bit engines
    send_msg();
    wait_res(1'b0);
    chk_msg_literals("string");
    pop(1'b0);

    // serial compatibility: one '1' bit
    beat(1'b1, 8'h01, 1'b1, 1'b1);
    @(negedge clk);
    chk("serial_state", st[4], 64'h8005);
    chk("serial_res", res[4], 64'h8005);
    chk("serial_res_valid", 64'(rv[4]), 64'd1);
    pop(1'b1);

    // backpressure: result held while consumer stalls
    send_msg();
    wait_res(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(rdy[0]), 64'd0);
      chk("bp_res_stable", res[0], 64'hFEE8);
    end
    pop(1'b0);

    // restart: partial frame discarded by a mid-frame sop
    beat(1'b0, 8'hA5, 1'b1, 1'b0);
    beat(1'b0, 8'h5A, 1'b0, 1'b0);
    beat(1'b0, 8'h3C, 1'b0, 1'b0);
    send_msg();
    wait_res(1'b0);
    chk_msg_literals("restart");
    pop(1'b0);

    // single-beat frame of 0x00
    beat(1'b0, 8'h00, 1'b1, 1'b1);
    wait_res(1'b0);
    chk("single_zero_buypass", res[0], 64'h0000);
    chk("single_zero_arc", res[1], 64'h0000);
    pop(1'b0);

    // async reset mid-frame, between clock edges
    beat(1'b0, 8'h11, 1'b1, 1'b0);
    beat(1'b0, 8'h22, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_ready", 64'(rdy[0]), 64'd1);
    chk("arst_mid_state", st[0], 64'd0);
    chk("arst_mid_state_crc32", st[3], 64'hFFFFFFFF);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_msg();
    wait_res(1'b0);
    chk_msg_literals("after_reset");

    // async reset while a result is pending
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result_valid", 64'(rv[0]), 64'd0);
    chk("arst_result_res", res[0], 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // random 8-bit frames with gaps, mid-frame restarts and consumer stalls
    for (int f = 0; f < 120; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        int gap;
        gap = $urandom_range(0, 3);
        if (gap == 3) begin @(posedge clk); #1; end
        beat(1'b0, 8'($urandom), (b == 0) || ($urandom_range(0, 9) == 0), b == len - 1);
      end
      wait_res(1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pop(1'b0);
    end

    // random serial frames
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 24);
      for (int b = 0; b < len; b++) beat(1'b1, 8'($urandom), b == 0, b == len - 1);
      wait_res(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pop(1'b1);
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
